// File: rtl/calc_cmd_sequencer_if.sv
// Command stream and calculator button bus shared by calc_cmd_sequencer and its environment.
interface calc_cmd_sequencer_if;
  localparam int unsigned NUM_W = 8;
  localparam int unsigned OP_W  = 2;

  logic [NUM_W-1:0] CmdNum;
  logic [OP_W-1:0]  CmdOp;
  logic             CmdValid;
  logic             CmdReady;
  logic [NUM_W-1:0] NumIn;
  logic [OP_W-1:0]  OpIn;
  logic             Enter;
  logic [NUM_W-1:0] NumOut;
  logic [NUM_W-1:0] Result;
  logic             ResultValid;
  logic             Busy;

  // Environment side: offers commands, drives the calculator accumulator back.
  modport master (
    output CmdNum, CmdOp, CmdValid, NumOut,
    input  CmdReady, NumIn, OpIn, Enter, Result, ResultValid, Busy
  );

  // Sequencer side.
  modport slave (
    input  CmdNum, CmdOp, CmdValid, NumOut,
    output CmdReady, NumIn, OpIn, Enter, Result, ResultValid, Busy
  );
endinterface

// File: rtl/calc_cmd_sequencer.sv
// Buffers calculator commands and replays each as a setup / Enter press / release
// sequence, returning the calculator's NumOut as a one-cycle result strobe.
module calc_cmd_sequencer #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic                 clock,
  input  logic                 Reset,
  calc_cmd_sequencer_if.slave  bus
);
  localparam int unsigned NUM_W    = 8;
  localparam int unsigned OP_W     = 2;
  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int unsigned MAX_WAIT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned TMR_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [NUM_W-1:0] num;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    PRESS   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  cmd_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  cmd_t             head;
  state_t           state;
  logic [TMR_W-1:0] timer;

  assign full         = (count == CNT_W'(FIFO_DEPTH));
  assign empty        = (count == '0);
  assign bus.CmdReady = !full;
  assign push         = bus.CmdValid && !full;
  // The result-strobe cycle is spent idle so consecutive commands are 3+HOLD+GAP apart.
  assign pop          = (state == IDLE) && !empty && !bus.ResultValid;
  assign head         = mem[rd_ptr];

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // FIFO storage write port.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= cmd_t'{op: bus.CmdOp, num: bus.CmdNum};
    end
  end

  // FIFO pointers and occupancy; reset empties the queue.
  always_ff @(posedge clock) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_next;
    end
  end

  // Button sequencing FSM with registered calculator-side outputs.
  always_ff @(posedge clock) begin
    if (Reset) begin
      state           <= IDLE;
      timer           <= '0;
      bus.NumIn       <= '0;
      bus.OpIn        <= '0;
      bus.Enter       <= 1'b0;
      bus.Result      <= '0;
      bus.ResultValid <= 1'b0;
      bus.Busy        <= 1'b0;
    end else begin
      bus.ResultValid <= 1'b0;
      case (state)
        IDLE: begin
          bus.Enter <= 1'b0;
          if (pop) begin
            bus.NumIn <= head.num;
            bus.OpIn  <= head.op;
            bus.Busy  <= 1'b1;
            state     <= SETUP;
          end else begin
            bus.Busy <= (count_next != '0);
          end
        end
        SETUP: begin
          bus.Enter <= 1'b1;
          bus.Busy  <= 1'b1;
          timer     <= TMR_W'(HOLD_CYCLES - 1);
          state     <= PRESS;
        end
        PRESS: begin
          if (timer == '0) begin
            bus.Enter <= 1'b0;
            timer     <= TMR_W'(GAP_CYCLES - 1);
            state     <= RELEASE;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        RELEASE: begin
          if (timer == '0) begin
            bus.Result      <= bus.NumOut;
            bus.ResultValid <= 1'b1;
            bus.Busy        <= (count_next != '0);
            state           <= IDLE;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        default: begin
          bus.Enter <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Bench for calc_cmd_sequencer: two instances (default and HOLD=GAP=1), a calculator
// model per instance, and a result scoreboard.
module tb_calc_cmd_sequencer;
  localparam int unsigned H_A = 2;
  localparam int unsigned G_A = 2;
  localparam int unsigned H_B = 1;
  localparam int unsigned G_B = 1;

  typedef struct {
    logic [7:0] val;
    int         t;
    logic       busy;
  } res_t;

  logic clock = 1'b0;
  logic Reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  calc_cmd_sequencer_if if_a ();
  calc_cmd_sequencer_if if_b ();

  calc_cmd_sequencer #(.FIFO_DEPTH(4), .HOLD_CYCLES(H_A), .GAP_CYCLES(G_A)) u_dut_a (
    .clock (clock),
    .Reset (Reset),
    .bus   (if_a.slave)
  );

  calc_cmd_sequencer #(.FIFO_DEPTH(4), .HOLD_CYCLES(H_B), .GAP_CYCLES(G_B)) u_dut_b (
    .clock (clock),
    .Reset (Reset),
    .bus   (if_b.slave)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  logic [7:0] num_in [2];
  logic [1:0] op_in  [2];
  logic [7:0] res    [2];
  logic       en     [2];
  logic       rv     [2];
  logic       busy   [2];
  logic       rdy    [2];
  assign num_in[0] = if_a.NumIn;  assign num_in[1] = if_b.NumIn;
  assign op_in[0]  = if_a.OpIn;   assign op_in[1]  = if_b.OpIn;
  assign res[0]    = if_a.Result; assign res[1]    = if_b.Result;
  assign en[0]     = if_a.Enter;  assign en[1]     = if_b.Enter;
  assign rv[0]     = if_a.ResultValid; assign rv[1] = if_b.ResultValid;
  assign busy[0]   = if_a.Busy;   assign busy[1]   = if_b.Busy;
  assign rdy[0]    = if_a.CmdReady; assign rdy[1]  = if_b.CmdReady;

  function automatic logic [7:0] calc_f(input logic [7:0] a, input logic [7:0] n, input logic [1:0] o);
    case (o)
      2'b00:   return a + n;
      2'b01:   return n - a;
      2'b10:   return a | n;
      default: return (n == a) ? 8'h01 : 8'h00;
    endcase
  endfunction

  // Calculator core model: START applies the op on Enter, WAIT holds until Enter drops.
  logic [7:0] acc   [2];
  logic       cwait [2];
  assign if_a.NumOut = acc[0];
  assign if_b.NumOut = acc[1];
  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (Reset) begin
        acc[i]   <= 8'h00;
        cwait[i] <= 1'b0;
      end else if (!cwait[i]) begin
        if (en[i]) begin
          acc[i]   <= calc_f(acc[i], num_in[i], op_in[i]);
          cwait[i] <= 1'b1;
        end
      end else if (!en[i]) begin
        cwait[i] <= 1'b0;
      end
    end
  end

  // Monitor: logs result strobes and Enter pulse/gap statistics.
  res_t got_q [2][$];
  int   clr_req = 0;
  int   clr_ack = 0;
  int   min_gap [2];
  int   min_hi  [2];
  int   max_hi  [2];
  int   pulses  [2];
  int   miss    [2];
  int   lo_run  [2];
  int   hi_run  [2];
  bit   have_fall [2];
  bit   en_prev   [2];
  always @(negedge clock) begin
    if (clr_req != clr_ack) begin
      clr_ack = clr_req;
      for (int i = 0; i < 2; i++) begin
        min_gap[i] = 1000; min_hi[i] = 1000; max_hi[i] = 0;
        pulses[i] = 0; miss[i] = 0; have_fall[i] = 0; lo_run[i] = 0; hi_run[i] = 0;
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (rv[i]) begin
        res_t r;
        r.val = res[i]; r.t = cyc; r.busy = busy[i];
        got_q[i].push_back(r);
      end
      if (en[i] && !en_prev[i]) begin
        if (cwait[i]) miss[i]++;
        if (have_fall[i] && lo_run[i] < min_gap[i]) min_gap[i] = lo_run[i];
        hi_run[i] = 1;
      end else if (en[i]) begin
        hi_run[i]++;
      end else if (en_prev[i]) begin
        pulses[i]++;
        if (hi_run[i] < min_hi[i]) min_hi[i] = hi_run[i];
        if (hi_run[i] > max_hi[i]) max_hi[i] = hi_run[i];
        have_fall[i] = 1;
        lo_run[i] = 1;
      end else begin
        lo_run[i]++;
      end
      en_prev[i] = en[i];
    end
  end

  logic [7:0] ref_acc [2];
  logic [7:0] exp_q   [2][$];
  int         got_rd  [2];

  task automatic drive_cmd(input int sel, input logic v, input logic [7:0] n, input logic [1:0] o);
    if (sel == 0) begin
      if_a.CmdValid = v; if_a.CmdNum = n; if_a.CmdOp = o;
    end else begin
      if_b.CmdValid = v; if_b.CmdNum = n; if_b.CmdOp = o;
    end
  endtask

  // Offer one command from a negedge; returns the accepting edge number.
  task automatic push_cmd(input int sel, input logic [7:0] n, input logic [1:0] o, output int a);
    bit r;
    bit ok = 0;
    a = -1;
    drive_cmd(sel, 1'b1, n, o);
    for (int k = 0; k < 200; k++) begin
      r = rdy[sel];
      @(negedge clock);
      if (r) begin
        ok = 1; a = cyc; break;
      end
    end
    if (ok) begin
      ref_acc[sel] = calc_f(ref_acc[sel], n, o);
      exp_q[sel].push_back(ref_acc[sel]);
    end else begin
      n_checks++;
      $display("FAIL push_accept sel=%0d: CmdReady stayed low, required accept within 200 cycles", sel);
    end
  endtask

  task automatic wait_results(input int sel, input int n, input int budget, output bit ok);
    ok = 0;
    for (int k = 0; k < budget; k++) begin
      if (got_q[sel].size() - got_rd[sel] >= n) begin
        ok = 1; break;
      end
      @(negedge clock);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    drive_cmd(0, 1'b0, 8'h00, 2'b00);
    drive_cmd(1, 1'b0, 8'h00, 2'b00);
    repeat (2) @(negedge clock);
    Reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ref_acc[i] = 8'h00;
      exp_q[i].delete();
      got_rd[i] = got_q[i].size();
    end
    clr_req++;
    @(negedge clock);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    drive_cmd(0, 1'b0, 8'h00, 2'b00);
    drive_cmd(1, 1'b0, 8'h00, 2'b00);
    repeat (3) @(negedge clock);
    Reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ref_acc[i] = 8'h00;
      got_rd[i] = got_q[i].size();
    end
    clr_req++;
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({num_in[i], op_in[i]} !== 10'h000) $display("FAIL reset_numin_opin dut%0d: got %h required 000", i, {num_in[i], op_in[i]});
      else n_pass++;
      n_checks++;
      if ({en[i], rv[i], busy[i]} !== 3'b000) $display("FAIL reset_enter_rv_busy dut%0d: got %b required 000", i, {en[i], rv[i], busy[i]});
      else n_pass++;
      n_checks++;
      if (res[i] !== 8'h00) $display("FAIL reset_result dut%0d: got %h required 00", i, res[i]);
      else n_pass++;
      n_checks++;
      if (rdy[i] !== 1'b1) $display("FAIL reset_cmdready dut%0d: got %b required 1", i, rdy[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_press();
    int a;
    bit seen = 0;
    int base;
    do_reset();
    push_cmd(0, 8'h11, 2'b00, a);
    push_cmd(0, 8'h22, 2'b00, a);
    drive_cmd(0, 1'b0, 8'h00, 2'b00);
    for (int k = 0; k < 20 && !seen; k++) begin
      if (en[0]) seen = 1;
      else @(negedge clock);
    end
    n_checks++;
    if (!seen) $display("FAIL midpress_enter_seen: got no Enter pulse, required one within 20 cycles");
    else n_pass++;
    Reset = 1'b1;
    @(negedge clock);
    n_checks++;
    if (en[0] !== 1'b0) $display("FAIL midpress_enter: got %b required 0", en[0]);
    else n_pass++;
    n_checks++;
    if (busy[0] !== 1'b0) $display("FAIL midpress_busy: got %b required 0", busy[0]);
    else n_pass++;
    n_checks++;
    if ({rdy[0], rv[0]} !== 2'b10) $display("FAIL midpress_ready_rv: got %b required 10", {rdy[0], rv[0]});
    else n_pass++;
    Reset = 1'b0;
    base = got_q[0].size();
    repeat (15) @(negedge clock);
    n_checks++;
    if (got_q[0].size() !== base) $display("FAIL midpress_no_result: got %0d results required 0", got_q[0].size() - base);
    else n_pass++;
    exp_q[0].delete();
    ref_acc[0] = 8'h00;
    got_rd[0] = got_q[0].size();
  endtask

  task automatic test_single();
    int a;
    bit ok;
    res_t r;
    logic [7:0] e;
    do_reset();
    push_cmd(0, 8'h05, 2'b00, a);
    drive_cmd(0, 1'b0, 8'h00, 2'b00);
    wait_results(0, 1, 40, ok);
    n_checks++;
    if (!ok) $display("FAIL single_timeout: got 0 results required 1 within 40 cycles");
    else n_pass++;
    if (ok) begin
      r = got_q[0][got_rd[0]]; got_rd[0]++;
      e = exp_q[0].pop_front();
      n_checks++;
      if (r.val !== 8'h05) $display("FAIL single_value: got %h required 05", r.val);
      else n_pass++;
      n_checks++;
      if (r.val !== e) $display("FAIL single_scoreboard: got %h required %h", r.val, e);
      else n_pass++;
      n_checks++;
      if (r.t !== a + 6) $display("FAIL single_latency: got edge %0d required %0d", r.t, a + 6);
      else n_pass++;
      n_checks++;
      if (r.busy !== 1'b0) $display("FAIL single_busy_at_result: got %b required 0", r.busy);
      else n_pass++;
    end
    repeat (3) @(negedge clock);
    n_checks++;
    if (pulses[0] !== 1 || min_hi[0] !== int'(H_A) || max_hi[0] !== int'(H_A))
      $display("FAIL single_enter_width: got pulses=%0d width %0d..%0d required 1 pulse of %0d", pulses[0], min_hi[0], max_hi[0], H_A);
    else n_pass++;
  endtask

  task automatic test_burst();
    logic [7:0] nums [4];
    logic [1:0] ops  [4];
    logic [7:0] lit  [4];
    int a;
    bit ok;
    int prev_t = 0;
    res_t r;
    logic [7:0] e;
    nums = '{8'h05, 8'h03, 8'hF0, 8'hFE};
    ops  = '{2'b00, 2'b01, 2'b10, 2'b11};
    lit  = '{8'h05, 8'hFE, 8'hFE, 8'h01};
    do_reset();
    for (int k = 0; k < 4; k++) push_cmd(0, nums[k], ops[k], a);
    drive_cmd(0, 1'b0, 8'h00, 2'b00);
    wait_results(0, 4, 80, ok);
    n_checks++;
    if (!ok) $display("FAIL burst_timeout: got %0d results required 4", got_q[0].size() - got_rd[0]);
    else n_pass++;
    if (ok) begin
      for (int k = 0; k < 4; k++) begin
        r = got_q[0][got_rd[0]]; got_rd[0]++;
        e = exp_q[0].pop_front();
        n_checks++;
        if (r.val !== lit[k] || r.val !== e) $display("FAIL burst_value[%0d]: got %h required %h", k, r.val, lit[k]);
        else n_pass++;
        n_checks++;
        if (r.busy !== (k < 3)) $display("FAIL burst_busy[%0d]: got %b required %b", k, r.busy, (k < 3));
        else n_pass++;
        if (k > 0) begin
          n_checks++;
          if (r.t - prev_t !== int'(3 + H_A + G_A)) $display("FAIL burst_period[%0d]: got %0d required %0d", k, r.t - prev_t, 3 + H_A + G_A);
          else n_pass++;
        end
        prev_t = r.t;
      end
    end
    n_checks++;
    if (pulses[0] !== 4 || min_gap[0] < int'(G_A + 2) || min_hi[0] !== int'(H_A) || max_hi[0] !== int'(H_A) || miss[0] !== 0)
      $display("FAIL burst_enter_shape: got pulses=%0d gap=%0d width %0d..%0d miss=%0d required 4 pulses, gap>=%0d, width %0d, miss 0",
               pulses[0], min_gap[0], min_hi[0], max_hi[0], miss[0], G_A + 2, H_A);
    else n_pass++;
  endtask

  task automatic test_fill();
    logic [7:0] nums [6];
    logic [1:0] ops  [6];
    int a [6];
    bit ok;
    res_t r;
    logic [7:0] e;
    nums = '{8'h10, 8'h01, 8'h33, 8'h44, 8'h0F, 8'h80};
    ops  = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b11, 2'b01};
    do_reset();
    for (int k = 0; k < 6; k++) push_cmd(0, nums[k], ops[k], a[k]);
    drive_cmd(0, 1'b0, 8'h00, 2'b00);
    n_checks++;
    if (a[4] - a[0] !== 4) $display("FAIL fill_fifth_accept: got edge +%0d required +4", a[4] - a[0]);
    else n_pass++;
    n_checks++;
    if (a[5] - a[0] !== 9) $display("FAIL fill_push_while_full: got edge +%0d required +9", a[5] - a[0]);
    else n_pass++;
    wait_results(0, 6, 120, ok);
    n_checks++;
    if (!ok) $display("FAIL fill_timeout: got %0d results required 6", got_q[0].size() - got_rd[0]);
    else n_pass++;
    if (ok) begin
      for (int k = 0; k < 6; k++) begin
        r = got_q[0][got_rd[0]]; got_rd[0]++;
        e = exp_q[0].pop_front();
        n_checks++;
        if (r.val !== e) $display("FAIL fill_value[%0d]: got %h required %h", k, r.val, e);
        else n_pass++;
      end
    end
  endtask

  task automatic test_sweep();
    logic [7:0] nums [3];
    logic [1:0] ops  [3];
    int a [3];
    bit ok;
    int prev_t = 0;
    res_t r;
    logic [7:0] e;
    nums = '{8'h07, 8'h02, 8'h05};
    ops  = '{2'b00, 2'b01, 2'b11};
    do_reset();
    for (int k = 0; k < 3; k++) push_cmd(1, nums[k], ops[k], a[k]);
    drive_cmd(1, 1'b0, 8'h00, 2'b00);
    wait_results(1, 3, 60, ok);
    n_checks++;
    if (!ok) $display("FAIL sweep_timeout: got %0d results required 3", got_q[1].size() - got_rd[1]);
    else n_pass++;
    if (ok) begin
      for (int k = 0; k < 3; k++) begin
        r = got_q[1][got_rd[1]]; got_rd[1]++;
        e = exp_q[1].pop_front();
        n_checks++;
        if (r.val !== e) $display("FAIL sweep_value[%0d]: got %h required %h", k, r.val, e);
        else n_pass++;
        n_checks++;
        if (k == 0 && r.t !== a[0] + int'(2 + H_B + G_B)) $display("FAIL sweep_latency: got edge %0d required %0d", r.t, a[0] + 2 + H_B + G_B);
        else if (k > 0 && r.t - prev_t !== int'(3 + H_B + G_B)) $display("FAIL sweep_period[%0d]: got %0d required %0d", k, r.t - prev_t, 3 + H_B + G_B);
        else n_pass++;
        prev_t = r.t;
      end
    end
    n_checks++;
    if (pulses[1] !== 3 || max_hi[1] !== int'(H_B) || min_gap[1] < int'(G_B + 2) || miss[1] !== 0)
      $display("FAIL sweep_enter_shape: got pulses=%0d width=%0d gap=%0d miss=%0d required 3, %0d, >=%0d, 0",
               pulses[1], max_hi[1], min_gap[1], miss[1], H_B, G_B + 2);
    else n_pass++;
  endtask

  task automatic test_random();
    int a;
    bit ok;
    int idle;
    int bad = 0;
    res_t r;
    logic [7:0] e;
    clr_req++;
    @(negedge clock);
    for (int k = 0; k < 20; k++) begin
      idle = int'($urandom_range(0, 2));
      if (idle > 0) begin
        drive_cmd(0, 1'b0, 8'h00, 2'b00);
        repeat (idle) @(negedge clock);
      end
      push_cmd(0, 8'($urandom), 2'($urandom), a);
    end
    drive_cmd(0, 1'b0, 8'h00, 2'b00);
    wait_results(0, 20, 400, ok);
    n_checks++;
    if (!ok) $display("FAIL random_timeout: got %0d results required 20", got_q[0].size() - got_rd[0]);
    else n_pass++;
    if (ok) begin
      for (int k = 0; k < 20; k++) begin
        r = got_q[0][got_rd[0]]; got_rd[0]++;
        e = exp_q[0].pop_front();
        if (r.val !== e) begin
          bad++;
          $display("FAIL random_value[%0d]: got %h required %h", k, r.val, e);
        end
      end
      n_checks++;
      if (bad != 0) $display("FAIL random_values: got %0d wrong results required 0", bad);
      else n_pass++;
    end
    repeat (20) @(negedge clock);
    n_checks++;
    if (got_q[0].size() - got_rd[0] !== 0 || exp_q[0].size() !== 0)
      $display("FAIL random_count: got %0d extra results, %0d missing required 0 and 0", got_q[0].size() - got_rd[0], exp_q[0].size());
    else n_pass++;
    n_checks++;
    if (miss[0] !== 0 || min_gap[0] < int'(G_A + 2)) $display("FAIL random_enter_gap: got miss=%0d gap=%0d required 0 and >=%0d", miss[0], min_gap[0], G_A + 2);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_reset_mid_press();
    test_single();
    test_burst();
    test_fill();
    test_sweep();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion required finish before 500000 time units");
    $fatal(1, "watchdog expired");
  end
endmodule
